reset_sequencer: RTL

//  Reset controller for the synchronizer flop chains. Holds NUM_DOMAINS active-low reset

---
 rtl/reset_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Sequenced reset release: hold all domains low, then release them one at a time,
// waiting for each domain's ready acknowledge (or a timeout) plus a gap.
module reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] i_dom_ready,
  output logic [NUM_DOMAINS-1:0] o_rst_n_out,
  output logic                   o_seq_busy,
  output logic                   o_seq_done,
  output logic [NUM_DOMAINS-1:0] o_seq_err
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAXC   = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
  localparam int CW     = $clog2(MAXC + 1);
  localparam int IW     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  // Terminal counts compared against cnt+1, one bit wider so the increment never wraps
  localparam logic [CW:0] HOLD_W = (CW+1)'(HOLD_CYCLES);
  localparam logic [CW:0] GAP_W  = (CW+1)'(GAP_CYCLES);
  localparam logic [CW:0] TMO_W  = (CW+1)'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {S_ASSERT, S_WAIT_RDY, S_GAP, S_RUN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [IW-1:0]          r_idx, w_idx_nxt;
  logic [NUM_DOMAINS-1:0] r_rst_n, w_rst_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic [NUM_DOMAINS-1:0] r_err, w_err_nxt;

  logic [CW:0]   w_cnt_inc;
  logic [IW-1:0] w_idx_p1;
  logic          w_rdy;
  logic          w_tmo;

  assign w_cnt_inc = {1'b0, r_cnt} + (CW+1)'(1);
  assign w_idx_p1  = r_idx + IW'(1);
  assign w_rdy     = i_dom_ready[r_idx];
  assign w_tmo     = (w_cnt_inc == TMO_W);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_rst_n;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    case (r_state)
      S_ASSERT: begin
        w_rst_nxt  = '0;
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b0;
        if (w_cnt_inc == HOLD_W) begin
          w_rst_nxt[0] = 1'b1;
          w_idx_nxt    = '0;
          w_state_nxt  = S_WAIT_RDY;
        end else begin
          w_cnt_nxt = w_cnt_inc[CW-1:0];
        end
      end
      S_WAIT_RDY: begin
        // A timeout is recorded, then handled exactly like a late ready
        if (w_rdy || w_tmo) begin
          if (!w_rdy) w_err_nxt[r_idx] = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else if (GAP_CYCLES == 0) begin
            w_rst_nxt[w_idx_p1] = 1'b1;
            w_idx_nxt           = w_idx_p1;
          end else begin
            w_state_nxt = S_GAP;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc[CW-1:0];
        end
      end
      S_GAP: begin
        if (w_cnt_inc == GAP_W) begin
          w_rst_nxt[w_idx_p1] = 1'b1;
          w_idx_nxt           = w_idx_p1;
          w_state_nxt         = S_WAIT_RDY;
        end else begin
          w_cnt_nxt = w_cnt_inc[CW-1:0];
        end
      end
      S_RUN: begin
        w_rst_nxt = '1;
      end
      default: begin
        w_state_nxt = S_ASSERT;
        w_idx_nxt   = '0;
        w_rst_nxt   = '0;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b0;
      end
    endcase
    // Software request overrides every other transition; counting resumes once it drops
    if (i_sw_rst_req) begin
      w_state_nxt = S_ASSERT;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_rst_nxt   = '0;
      w_busy_nxt  = 1'b1;
      w_done_nxt  = 1'b0;
      w_err_nxt   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_rst_n <= w_rst_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_rst_n_out = r_rst_n;
  assign o_seq_busy  = r_busy;
  assign o_seq_done  = r_done;
  assign o_seq_err   = r_err;

endmodule
